if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch stage bus: control inputs, instruction ROM port and IF/ID register outputs
interface if_stage_if;
  logic [1:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  modport master (
    input  stall, flush, new_pc, branch_flag, branch_target, rom_inst,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid
  );

  modport slave (
    output stall, flush, new_pc, branch_flag, branch_target, rom_inst,
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, ROM addressing and IF/ID pipeline register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic        rom_ce;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        hold_pc;
  logic        hold_id;

  // stall=2'b10 never comes from control; treating it like 2'b11 keeps PC and IF/ID consistent
  assign hold_id = bus.stall[1];
  assign hold_pc = bus.stall[0] | bus.stall[1];

  always_comb begin
    pc_next = pc;
    if (bus.flush) begin
      pc_next = {bus.new_pc[31:2], 2'b00};
    end else if (hold_pc) begin
      pc_next = pc;
    end else if (bus.branch_flag) begin
      pc_next = {bus.branch_target[31:2], 2'b00};
    end else begin
      pc_next = pc + 32'd4;
    end
  end

  // PC only advances once the ROM is enabled, so the first fetch is always the reset address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce <= 1'b0;
      pc     <= RESET_PC_ALIGNED;
    end else begin
      rom_ce <= 1'b1;
      if (rom_ce) begin
        pc <= pc_next;
      end
    end
  end

  // The delay-slot instruction is captured normally on a branch edge; only flush squashes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
    end else if (bus.flush) begin
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
    end else if (hold_id) begin
      id_pc    <= id_pc;
      id_inst  <= id_inst;
      id_valid <= id_valid;
    end else if (bus.stall[0]) begin
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
    end else begin
      id_pc    <= pc;
      id_inst  <= bus.rom_inst;
      id_valid <= rom_ce;
    end
  end

  assign bus.rom_ce   = rom_ce;
  assign bus.rom_addr = pc;
  assign bus.id_pc    = id_pc;
  assign bus.id_inst  = id_inst;
  assign bus.id_valid = id_valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a behavioural fetch model
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word k holds 32'h1000_0000 + k
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign bus.rom_inst = bus.rom_ce ? rom_word(bus.rom_addr) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected architectural state after each edge
  logic        m_ce;
  logic [31:0] m_pc;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;
  logic        m_idvalid;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ce      <= 1'b0;
      m_pc      <= RESET_PC;
      m_idpc    <= 32'h0;
      m_idinst  <= 32'h0;
      m_idvalid <= 1'b0;
    end else begin
      m_ce <= 1'b1;
      if (bus.flush || (bus.stall[0] && !bus.stall[1])) begin
        m_idpc    <= 32'h0;
        m_idinst  <= 32'h0;
        m_idvalid <= 1'b0;
      end else if (!bus.stall[1]) begin
        m_idpc    <= m_pc;
        m_idinst  <= m_ce ? rom_word(m_pc) : 32'h0;
        m_idvalid <= m_ce;
      end
      if (m_ce) begin
        if (bus.flush)
          m_pc <= bus.new_pc & 32'hFFFF_FFFC;
        else if (bus.stall == 2'b00)
          m_pc <= bus.branch_flag ? (bus.branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    check("rom_ce",   {31'h0, bus.rom_ce},   {31'h0, m_ce});
    check("rom_addr", bus.rom_addr,          m_pc);
    check("id_pc",    bus.id_pc,             m_idpc);
    check("id_inst",  bus.id_inst,           m_idinst);
    check("id_valid", {31'h0, bus.id_valid}, {31'h0, m_idvalid});
  end

  // Drive inputs just after a falling edge, then return 2ns after the next falling edge
  task automatic step(input logic [1:0] s, input logic f, input logic [31:0] np,
                      input logic b, input logic [31:0] bt);
    bus.stall         = s;
    bus.flush         = f;
    bus.new_pc        = np;
    bus.branch_flag   = b;
    bus.branch_target = bt;
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.stall = 2'b00; bus.flush = 1'b0; bus.new_pc = 32'h0;
    bus.branch_flag = 1'b0; bus.branch_target = 32'h0;
    @(negedge clk); #2;
    idle();
    check("reset rom_ce", {31'h0, bus.rom_ce}, 32'h0);
    check("reset id_valid", {31'h0, bus.id_valid}, 32'h0);

    rst = 1'b1;
    #1 check("release rom_ce before edge", {31'h0, bus.rom_ce}, 32'h0);
    idle();
    check("edge1 rom_ce", {31'h0, bus.rom_ce}, 32'h1);
    check("edge1 rom_addr", bus.rom_addr, 32'h0);
    check("edge1 id_valid", {31'h0, bus.id_valid}, 32'h0);
    idle();
    check("edge2 id_inst", bus.id_inst, 32'h1000_0000);
    check("edge2 rom_addr", bus.rom_addr, 32'h4);
    idle();
    check("edge3 id_inst", bus.id_inst, 32'h1000_0001);
    idle();
    check("id_pc before branch", bus.id_pc, 32'h8);

    step(2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0042);
    check("delay slot id_pc", bus.id_pc, 32'hC);
    check("delay slot id_inst", bus.id_inst, 32'h1000_0003);
    check("branch rom_addr", bus.rom_addr, 32'h40);
    idle();
    check("target id_inst", bus.id_inst, 32'h1000_0010);

    step(2'b00, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    check("redirect rom_addr", bus.rom_addr, 32'h10);
    step(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
    step(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall01 pc hold", bus.rom_addr, 32'h10);
    check("stall01 bubble", {31'h0, bus.id_valid}, 32'h0);
    idle();
    check("after stall01 id_pc", bus.id_pc, 32'h10);
    idle();
    check("no duplicate id_pc", bus.id_pc, 32'h14);

    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 32'h0, 1'b1, 32'h100);
    check("stall11 id_pc", bus.id_pc, 32'h14);
    check("stall11 rom_addr", bus.rom_addr, 32'h18);
    step(2'b10, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall10 id_inst", bus.id_inst, 32'h1000_0005);
    idle();
    check("resume id_pc", bus.id_pc, 32'h18);
    idle();

    step(2'b11, 1'b1, 32'h0000_0181, 1'b1, 32'h40);
    check("flush rom_addr", bus.rom_addr, 32'h180);
    check("flush id_valid", {31'h0, bus.id_valid}, 32'h0);
    idle();
    check("post flush id_pc", bus.id_pc, 32'h180);

    step(2'b00, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    check("top pc", bus.rom_addr, 32'hFFFF_FFFC);
    idle();
    check("wrap rom_addr", bus.rom_addr, 32'h0);
    check("wrap id_inst", bus.id_inst, 32'h4FFF_FFFF);
    idle();

    step(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
    #1 rst = 1'b0;
    #1;
    check("async rom_ce", {31'h0, bus.rom_ce}, 32'h0);
    check("async rom_addr", bus.rom_addr, RESET_PC);
    check("async id_inst", bus.id_inst, 32'h0);
    step(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
    check("held reset rom_ce", {31'h0, bus.rom_ce}, 32'h0);
    rst = 1'b1;
    idle();
    check("restart rom_addr", bus.rom_addr, RESET_PC);
    check("restart rom_ce", {31'h0, bus.rom_ce}, 32'h1);
    idle();
    check("restart id_inst", bus.id_inst, 32'h1000_0000);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
